// File: rtl/iterated_signed_divmod_stream_if.sv
// iterated_signed_divmod_stream_if: operand/result valid-ready bundle; abort exists only with ITER_DIV_ABORT_EN
interface iterated_signed_divmod_stream_if #(
    parameter int NWIDTH = 8,
    parameter int DWIDTH = 6
);
    logic              in_valid;
    logic              in_ready;
    logic              in_floor;
    logic [NWIDTH-1:0] numerator;
    logic [DWIDTH-1:0] denominator;
    logic              out_valid;
    logic              out_ready;
`ifdef ITER_DIV_ABORT_EN
    logic              abort;
`endif
    logic [NWIDTH-1:0] quotient;
    logic [DWIDTH-1:0] remainder;
    logic              div_zero;
    logic              overflow;
    modport slave (
        input  in_valid, in_floor, numerator, denominator, out_ready,
`ifdef ITER_DIV_ABORT_EN
        input  abort,
`endif
        output in_ready, out_valid, quotient, remainder, div_zero, overflow
    );
    modport master (
        output in_valid, in_floor, numerator, denominator, out_ready,
`ifdef ITER_DIV_ABORT_EN
        output abort,
`endif
        input  in_ready, out_valid, quotient, remainder, div_zero, overflow
    );
endinterface

// File: rtl/iterated_signed_divmod_stream.sv
// iterated_signed_divmod_stream: multi-cycle signed divider with truncate/floor rounding and stream handshakes.
// Optional ITER_DIV_ABORT_EN adds an abort input that returns any busy state to IDLE.
module iterated_signed_divmod_stream #(
    parameter int NWIDTH = 8,
    parameter int DWIDTH = 6,
    parameter int STEPS  = 1
) (
    input logic clk,
    input logic reset,
    iterated_signed_divmod_stream_if.slave s
);
    localparam int C  = NWIDTH / STEPS;
    localparam int CW = $clog2(C + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX, HOLD} state_t;
    state_t            state, state_nx;
    logic [NWIDTH-1:0] n_r, qm, qm_nx, q_s, q_f, q_o;
    logic [DWIDTH-1:0] d_r, r_s, r_f, r_o;
    logic [NWIDTH:0]   dm, pr, pr_nx, t, d_ext;
    logic [CW-1:0]     cnt;
    logic              fl_r, adj, dz, ov, dz_o, ov_o, ab, sn, sd, accept;
`ifdef ITER_DIV_ABORT_EN
    assign ab = s.abort;
`else
    assign ab = 1'b0;
`endif
    assign sn     = n_r[NWIDTH-1];
    assign sd     = d_r[DWIDTH-1];
    assign accept = state == IDLE && s.in_valid;
    assign d_ext  = {{(NWIDTH+1-DWIDTH){s.denominator[DWIDTH-1]}}, s.denominator};
    // qm starts as |n| and shifts dividend bits out the top while quotient bits enter at the bottom
    always_comb begin
        pr_nx = pr;
        qm_nx = qm;
        t     = '0;
        for (int i = 0; i < STEPS; i++) begin
            t     = {pr_nx[NWIDTH-1:0], qm_nx[NWIDTH-1]};
            qm_nx = {qm_nx[NWIDTH-2:0], t >= dm};
            pr_nx = t >= dm ? t - dm : t;
        end
    end
    always_comb begin
        q_s = (sn ^ sd) ? -qm : qm;
        r_s = sn ? -pr[DWIDTH-1:0] : pr[DWIDTH-1:0];
        adj = fl_r && |r_s && (r_s[DWIDTH-1] != sd);
        q_f = adj ? q_s - NWIDTH'(1) : q_s;
        r_f = adj ? r_s + d_r : r_s;
        dz  = d_r == '0;
        ov  = n_r == {1'b1, {(NWIDTH-1){1'b0}}} && &d_r;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = s.in_valid ? CALC : IDLE;
            CALC:    state_nx = cnt == '0 ? FIX : CALC;
            FIX:     state_nx = HOLD;
            HOLD:    state_nx = s.out_ready ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
        if (ab && state != IDLE) state_nx = IDLE;
    end
    // the first CALC cycle (cnt == C) is an alignment slot; the C steps run with cnt C-1..0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            n_r   <= '0;
            d_r   <= '0;
            fl_r  <= 1'b0;
            qm    <= '0;
            dm    <= '0;
            pr    <= '0;
            cnt   <= '0;
            q_o   <= '0;
            r_o   <= '0;
            dz_o  <= 1'b0;
            ov_o  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                n_r  <= s.numerator;
                d_r  <= s.denominator;
                fl_r <= s.in_floor;
                qm   <= s.numerator[NWIDTH-1] ? -s.numerator : s.numerator;
                dm   <= s.denominator[DWIDTH-1] ? -d_ext : d_ext;
                pr   <= '0;
                cnt  <= CW'(C);
                dz_o <= 1'b0;
                ov_o <= 1'b0;
            end
            if (state == CALC) begin
                cnt <= cnt - CW'(1);
                if (cnt != CW'(C)) begin
                    qm <= qm_nx;
                    pr <= pr_nx;
                end
            end
            if (state == FIX && !ab) begin
                q_o  <= dz ? '1 : q_f;
                r_o  <= dz ? '0 : r_f;
                dz_o <= dz;
                ov_o <= ov;
            end
        end
    end
    assign s.in_ready  = state == IDLE;
    assign s.out_valid = state == HOLD;
    assign s.quotient  = q_o;
    assign s.remainder = r_o;
    assign s.div_zero  = dz_o;
    assign s.overflow  = ov_o;
endmodule

// File: tb/tb_iterated_signed_divmod_stream.sv
// tb_iterated_signed_divmod_stream: random and directed stimulus against an arithmetic reference model.
module tb_iterated_signed_divmod_stream;
    parameter int STEPS = 1;
    localparam int NW = 8;
    localparam int DW = 6;
    localparam int C  = NW / STEPS;
    typedef struct packed {
        logic [NW-1:0] q;
        logic [DW-1:0] r;
        logic          dz;
        logic          ov;
    } res_t;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    res_t expq[$];
    always #5 clk = ~clk;
    iterated_signed_divmod_stream_if #(.NWIDTH(NW), .DWIDTH(DW)) bus ();
    iterated_signed_divmod_stream #(.NWIDTH(NW), .DWIDTH(DW), .STEPS(STEPS)) dut (
        .clk(clk),
        .reset(reset),
        .s(bus)
    );
    function automatic res_t model(input int n, input int d, input bit fl);
        res_t res;
        int   q, r;
        if (d == 0) return {{NW{1'b1}}, {DW{1'b0}}, 2'b10};
        q = n / d;
        r = n % d;
        if (fl && r != 0 && ((r < 0) != (d < 0))) begin
            q = q - 1;
            r = r + d;
        end
        res.q  = NW'(q);
        res.r  = DW'(r);
        res.dz = 1'b0;
        res.ov = n == -(1 << (NW - 1)) && d == -1;
        return res;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    // scoreboard: every cycle a result is presented it must equal the oldest expected one
    always @(negedge clk) begin
        if (reset) expq.delete();
        else begin
            if (bus.out_valid) begin
                checks++;
                if (expq.size() == 0) $display("FAIL scoreboard: out_valid with no pending operation");
                else if ({bus.quotient, bus.remainder, bus.div_zero, bus.overflow} === expq[0]) passes++;
                else $display("FAIL scoreboard: got q=%0h r=%0h dz=%0b ov=%0b expected q=%0h r=%0h dz=%0b ov=%0b",
                              bus.quotient, bus.remainder, bus.div_zero, bus.overflow,
                              expq[0].q, expq[0].r, expq[0].dz, expq[0].ov);
                if (bus.out_ready && expq.size() > 0) void'(expq.pop_front());
            end
            if (bus.in_valid && bus.in_ready)
                expq.push_back(model(int'($signed(bus.numerator)), int'($signed(bus.denominator)), bus.in_floor));
        end
    end
    task automatic op(input int n, input int d, input bit fl, input int stall, output res_t got, output int lat);
        bus.numerator   = NW'(n);
        bus.denominator = DW'(d);
        bus.in_floor    = fl;
        bus.in_valid    = 1'b1;
        bus.out_ready   = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.numerator   = NW'($urandom);
        bus.denominator = DW'($urandom);
        bus.in_floor    = ~fl;
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 60) chk("timeout", 32'(bus.out_valid), 1);
        got = {bus.quotient, bus.remainder, bus.div_zero, bus.overflow};
        for (int i = 0; i < stall; i++) begin
            bus.in_valid  = 1'($urandom_range(1));
            bus.numerator = NW'($urandom);
            @(posedge clk);
            #1;
            chk("stall_stable", {bus.quotient, bus.remainder, bus.div_zero, bus.overflow}, got);
            chk("stall_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask
    task automatic rand_op(input int n, input int d, input bit fl, input int stall);
        res_t got;
        int   lat, qs, rs;
        bit   ok;
        op(n, d, fl, stall, got, lat);
        qs = int'($signed(got.q));
        rs = int'($signed(got.r));
        if (d != 0 && !(n == -128 && d == -1)) begin
            chk("identity", 32'(d * qs + rs), 32'(n));
            ok = rs == 0 || (((rs < 0) == ((fl ? d : n) < 0)) && (rs < 0 ? -rs : rs) < (d < 0 ? -d : d));
            chk("rem_rule", 32'(ok), 1);
        end
    endtask
    initial begin
        res_t got;
        int   lat;
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_floor    = 1'b0;
        bus.numerator   = '0;
        bus.denominator = '0;
        bus.out_ready   = 1'b0;
`ifdef ITER_DIV_ABORT_EN
        bus.abort       = 1'b0;
`endif
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_outputs", {bus.quotient, bus.remainder, bus.div_zero, bus.overflow}, 0);
        chk("model_7_n2_trunc", model(7, -2, 0), {8'hFD, 6'h01, 2'b00});
        chk("model_7_n2_floor", model(7, -2, 1), {8'hFC, 6'h3F, 2'b00});
        chk("model_min_n1", model(-128, -1, 0), {8'h80, 6'h00, 2'b01});
        chk("model_5_0", model(5, 0, 0), {8'hFF, 6'h00, 2'b10});
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        op(7, -2, 0, 0, got, lat);
        chk("trunc_7_n2", got, {8'hFD, 6'h01, 2'b00});
        chk("latency", 32'(lat), 32'(C + 2));
        op(7, -2, 1, 0, got, lat);
        chk("floor_7_n2", got, {8'hFC, 6'h3F, 2'b00});
        op(-128, -1, 0, 0, got, lat);
        chk("ovf_min_n1", got, {8'h80, 6'h00, 2'b01});
        op(-128, -32, 0, 0, got, lat);
        chk("min_n32", got, {8'h04, 6'h00, 2'b00});
        op(5, 0, 0, 0, got, lat);
        chk("div0_pos", got, {8'hFF, 6'h00, 2'b10});
        op(-5, 0, 1, 0, got, lat);
        chk("div0_neg", got, {8'hFF, 6'h00, 2'b10});
        chk("div0_latency", 32'(lat), 32'(C + 2));
        op(-9, 4, 0, 5, got, lat);
        chk("stall_result", got, {8'hFE, 6'h3F, 2'b00});
        chk("idle_after_hold", 32'(bus.in_ready), 1);
        bus.numerator   = NW'(55);
        bus.denominator = DW'(3);
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midcalc_rst_out_valid", 32'(bus.out_valid), 0);
        chk("midcalc_rst_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        op(100, 7, 0, 0, got, lat);
        chk("after_rst_100_7", got, {8'd14, 6'd2, 2'b00});
        foreach (got.q[i]) begin end
        for (int a = 0; a < 5; a++)
            for (int b = 0; b < 5; b++)
                for (int f = 0; f < 2; f++) begin
                    int nv[5] = '{-128, 127, -1, 0, 1};
                    int dv[5] = '{-32, 31, -1, 1, 0};
                    rand_op(nv[a], dv[b], f[0], 0);
                end
        for (int k = 0; k < 300; k++)
            rand_op(int'($urandom_range(255)) - 128, int'($urandom_range(63)) - 32,
                    1'($urandom_range(1)), int'($urandom_range(2)));
        chk("queue_drained", 32'(expq.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
